// File: rtl/bf_pkg.sv
// Purpose     : shared opcode bytes, controller state encoding and decoded-op layout
//               for the Brainfuck machine sequencing controller.
// Latency     : n/a (declarations only).
// Backpressure: n/a.
// Contents:
//   DEPTH_W_DEF  default width of the bracket nesting counter
//   OP_*         ASCII opcode bytes as fetched from program memory
//   bf_state_e   controller state encoding
//   bf_op_t      one-hot decoded opcode, exactly one field set per byte
package bf_pkg;

  localparam int DEPTH_W_DEF = 8;

  localparam logic [7:0] OP_INC_DP = 8'h3E;  // >
  localparam logic [7:0] OP_DEC_DP = 8'h3C;  // <
  localparam logic [7:0] OP_INC    = 8'h2B;  // +
  localparam logic [7:0] OP_DEC    = 8'h2D;  // -
  localparam logic [7:0] OP_OUT    = 8'h2E;  // .
  localparam logic [7:0] OP_IN     = 8'h2C;  // ,
  localparam logic [7:0] OP_LOOP   = 8'h5B;  // [
  localparam logic [7:0] OP_END    = 8'h5D;  // ]
  localparam logic [7:0] OP_HALT   = 8'h00;  // end of program

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXEC      = 3'd2,
    ST_OUT       = 3'd3,
    ST_IN        = 3'd4,
    ST_SCAN_WAIT = 3'd5,
    ST_SCAN_CHK  = 3'd6,
    ST_HALT      = 3'd7
  } bf_state_e;

  // One-hot decode of an instruction byte; nop covers every byte that is
  // not a recognised opcode (comments in BF source are just NOPs).
  typedef struct packed {
    logic inc_dp;
    logic dec_dp;
    logic inc_d;
    logic dec_d;
    logic put;
    logic get;
    logic loop;
    logic loop_end;
    logic halt;
    logic nop;
  } bf_op_t;

endpackage

// File: rtl/bf_decode.sv
// Purpose     : combinational ASCII byte -> one-hot opcode decode, shared by the
//               execute and bracket-scan paths of the controller.
// Latency     : 0 cycles (pure combinational).
// Backpressure: none.
// Ports:
//   instr  in   8   instruction byte at the current PC
//   op     out  10  one-hot decoded opcode (bf_op_t)
module bf_decode
  import bf_pkg::*;
(
  input  logic [7:0] instr,
  output bf_op_t     op
);

  always_comb begin
    op = '0;
    case (instr)
      OP_INC_DP: op.inc_dp   = 1'b1;
      OP_DEC_DP: op.dec_dp   = 1'b1;
      OP_INC:    op.inc_d    = 1'b1;
      OP_DEC:    op.dec_d    = 1'b1;
      OP_OUT:    op.put      = 1'b1;
      OP_IN:     op.get      = 1'b1;
      OP_LOOP:   op.loop     = 1'b1;
      OP_END:    op.loop_end = 1'b1;
      OP_HALT:   op.halt     = 1'b1;
      default:   op.nop      = 1'b1;
    endcase
  end

endmodule

// File: rtl/bf_control_fsm.sv
// Purpose     : sequencing controller for the Brainfuck datapath; fetches and decodes
//               the byte at PC, drives PC/DP/cell load + DecInc selects, scans brackets.
// Latency     : 2 cycles per simple instruction, +handshake wait for '.'/',',
//               +2 cycles per scanned byte for a taken bracket.
// Backpressure: '.' holds out_valid until out_ready; ',' holds in_ready until in_valid.
//
// Optional feature macro: BF_CTRL_ERR_EN -- when defined, err is a sticky flag set on
// nesting-depth overflow or on an unmatched '[' (program end reached while scanning
// forward); when undefined, err is tied 0 and depth wraps silently.
//
// Ports:
//   clock, resetn            clock (rising edge) and async active-low reset
//   start                    one-cycle start pulse, only honoured in IDLE
//   instr                    program byte at PC, valid one cycle after PCLd/start
//   data_zero                current cell == 0, valid one cycle after DPLd/DLd
//   in_valid / in_ready      input byte handshake (',')
//   out_valid / out_ready    output byte handshake ('.')
//   PCLd, PCDecInc           PC load, 1 = PC-1, 0 = PC+1
//   DPLd, DPDecInc           data-pointer load, 1 = DP-1, 0 = DP+1
//   DLd, DDecInc, DSel       cell write, 1 = cell-1 / 0 = cell+1, DSel 1 = input byte
//   halted, err              program finished, error flag
module bf_control_fsm
  import bf_pkg::*;
#(
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic start,
  input  logic [7:0] instr,
  input  logic data_zero,
  input  logic in_valid,
  input  logic out_ready,
  output logic PCLd,
  output logic PCDecInc,
  output logic DPLd,
  output logic DPDecInc,
  output logic DLd,
  output logic DDecInc,
  output logic DSel,
  output logic in_ready,
  output logic out_valid,
  output logic halted,
  output logic err
);

  localparam logic [2:0] S_IDLE      = ST_IDLE;
  localparam logic [2:0] S_FETCH     = ST_FETCH;
  localparam logic [2:0] S_EXEC      = ST_EXEC;
  localparam logic [2:0] S_OUT       = ST_OUT;
  localparam logic [2:0] S_IN        = ST_IN;
  localparam logic [2:0] S_SCAN_WAIT = ST_SCAN_WAIT;
  localparam logic [2:0] S_SCAN_CHK  = ST_SCAN_CHK;
  localparam logic [2:0] S_HALT      = ST_HALT;

  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  logic [2:0]         state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d, depth_nxt;
  logic               dir_q, dir_d;     // 0 = forward scan, 1 = backward scan
  logic               nest, unnest;
  bf_op_t             op;

`ifdef BF_CTRL_ERR_EN
  logic err_q;
  logic err_set;
`endif

  bf_decode u_decode (
    .instr (instr),
    .op    (op)
  );

  // A backward scan walks toward the matching '[', so the bracket that opens
  // a nested level is ']' and the one that closes it is '['.
  assign nest      = dir_q ? op.loop_end : op.loop;
  assign unnest    = dir_q ? op.loop     : op.loop_end;
  assign depth_nxt = nest   ? depth_q + DEPTH_ONE :
                     unnest ? depth_q - DEPTH_ONE : depth_q;

  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    dir_d     = dir_q;
    PCLd      = 1'b0;
    PCDecInc  = 1'b0;
    DPLd      = 1'b0;
    DPDecInc  = 1'b0;
    DLd       = 1'b0;
    DDecInc   = 1'b0;
    DSel      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
`ifdef BF_CTRL_ERR_EN
    err_set   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      // instr is not yet valid for the freshly loaded PC
      S_FETCH: state_d = S_EXEC;

      S_EXEC: begin
        case (1'b1)
          op.inc_dp, op.dec_dp: begin
            DPLd     = 1'b1;
            DPDecInc = op.dec_dp;
            PCLd     = 1'b1;
            state_d  = S_FETCH;
          end
          op.inc_d, op.dec_d: begin
            DLd     = 1'b1;
            DDecInc = op.dec_d;
            PCLd    = 1'b1;
            state_d = S_FETCH;
          end
          op.put: state_d = S_OUT;
          op.get: state_d = S_IN;
          op.loop: begin
            PCLd = 1'b1;
            if (data_zero) begin
              depth_d = DEPTH_ONE;
              dir_d   = 1'b0;
              state_d = S_SCAN_WAIT;
            end else begin
              state_d = S_FETCH;
            end
          end
          op.loop_end: begin
            PCLd = 1'b1;
            if (!data_zero) begin
              depth_d  = DEPTH_ONE;
              dir_d    = 1'b1;
              PCDecInc = 1'b1;
              state_d  = S_SCAN_WAIT;
            end else begin
              state_d = S_FETCH;
            end
          end
          op.halt: state_d = S_HALT;
          op.nop: begin
            PCLd    = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            PCLd    = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          PCLd    = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          DLd     = 1'b1;
          DSel    = 1'b1;
          PCLd    = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_SCAN_WAIT: state_d = S_SCAN_CHK;

      S_SCAN_CHK: begin
        if (!dir_q && op.halt) begin
          // program ended inside an unmatched '['
          state_d = S_HALT;
`ifdef BF_CTRL_ERR_EN
          err_set = 1'b1;
`endif
        end
`ifdef BF_CTRL_ERR_EN
        else if (nest && (depth_q == '1)) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
`endif
        else begin
          depth_d = depth_nxt;
          PCLd    = 1'b1;
          if (depth_nxt == '0) begin
            // matched: step past the bracket in either direction
            state_d = S_FETCH;
          end else begin
            PCDecInc = dir_q;
            state_d  = S_SCAN_WAIT;
          end
        end
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      dir_q   <= dir_d;
    end
  end

`ifdef BF_CTRL_ERR_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
